// File: rtl/decoder_proj_pkg.sv
// decoder_proj_pkg: shared constants and state type for the decoder input path.
package decoder_proj_pkg;
    localparam int CODE_W = 7;
    localparam int DEBOUNCE_DEFAULT = 4;
    typedef enum logic {IN_IDLE, IN_PEND} in_state_t;
endpackage

// File: rtl/decoder_in_sync.sv
// decoder_in_sync: two-flop synchroniser for an asynchronous pad bus.
module decoder_in_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sync1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            q     <= '0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end
endmodule

// File: rtl/decoder_in_stage.sv
// decoder_in_stage: synchronise and debounce the pad bus, hand each new stable code to the decoder.
module decoder_in_stage
    import decoder_proj_pkg::*;
#(
    parameter int WIDTH           = CODE_W,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] code_out,
    output logic             code_valid,
    input  logic             code_ready,
    output logic             overrun
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync2, cand, accepted;
    logic [CW-1:0] cnt;
    logic acc_vld, stable, load, set_ovr;
    in_state_t state, state_next;

    decoder_in_sync #(.WIDTH(WIDTH)) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (raw_in),
        .q    (sync2)
    );

    // A code already handed over is never re-offered until a different one intervenes.
    assign stable     = cnt == CNT_MAX && sync2 == cand && (!acc_vld || cand != accepted);
    assign code_valid = state == IN_PEND;

    always_comb begin
        load       = stable && (state == IN_IDLE || code_ready);
        set_ovr    = stable && state == IN_PEND && !code_ready;
        state_next = load ? IN_PEND : (state == IN_PEND && code_ready) ? IN_IDLE : state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand <= '0;
            cnt  <= '0;
        end else if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IN_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            code_out <= '0;
            accepted <= '0;
            acc_vld  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (load) begin
                code_out <= cand;
                accepted <= cand;
                acc_vld  <= 1'b1;
            end
            if (set_ovr) overrun <= 1'b1;
        end
    end
endmodule
